modinv_sequencer: RTL and testbench
===================================

Name: modinv_sequencer

Overview:
Top-level controller for the modular invertor (almost-inverse algorithm). It starts the helper blocks in order and handshakes each one: init, then repeated step until v==0, then k halvings, then copy-out. It counts iterations (k), detects non-invertible operands via an iteration limit, and reports rdy/err to the ECDSA datapath above it. It contains no datapath; helpers own all buffer access.

Parameters:
OPERAND_NUM_WORDS, 8, operand width in 32-bit words.
K_NUM_BITS, 10, width of k counter; must hold K_MAX = 64*OPERAND_NUM_WORDS (512 at default).
TIMEOUT_CYCLES, 1023, watchdog limit per helper wait (optional feature only).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  start request, sampled only when rdy=1
rdy  out  1  idle / result valid
err  out  1  last run failed (non-invertible or timeout)
k_dout  out  K_NUM_BITS  step count of last run
init_ena  out  1  start pulse to init helper
init_rdy  in  1  init helper idle
step_ena  out  1  start pulse to step helper
step_rdy  in  1  step helper idle
step_v_zero  in  1  v==0 after last step; valid while step_rdy=1
halve_ena  out  1  start pulse to halve helper (r := r/2 mod q)
halve_rdy  in  1  halve helper idle
copy_ena  out  1  start pulse to copy-out helper
copy_rdy  in  1  copy helper idle

Behaviour:
- Reset: state IDLE; rdy=1, err=0, k_dout=0, every *_ena=0, halve_cnt=0. Takes effect immediately and overrides any operation in flight; helpers are reset by the same rst_n.
- rdy = (state==IDLE), combinational. ena is ignored in every other state.
- Helper handshake: each X_ena is a one-cycle pulse, asserted combinationally in X_TRIG only while X_rdy=1. The FSM stays in X_TRIG until X_rdy=1, then moves to X_WAIT. Helper rdy falls on the edge after the pulse. X_WAIT exits on the first cycle X_rdy=1.
- States and transitions:
  - IDLE: on ena, clear err, k, halve_cnt; go to INIT_TRIG.
  - INIT_TRIG -> INIT_WAIT -> STEP_TRIG.
  - STEP_TRIG -> STEP_WAIT.
  - STEP_WAIT, on step_rdy: k <= k+1.
    - If step_v_zero: halve_cnt <= k+1; go to HALVE_TRIG.
    - Else if k+1 == K_MAX: err <= 1; go to IDLE (no halve, no copy).
    - Else: go to STEP_TRIG.
    - v_zero is checked before the limit, so success on exactly the K_MAX-th step is not an error.
  - HALVE_TRIG (pulse fires): halve_cnt <= halve_cnt-1; go to HALVE_WAIT.
  - HALVE_WAIT, on halve_rdy: if halve_cnt==0 go to COPY_TRIG, else go to HALVE_TRIG.
  - COPY_TRIG -> COPY_WAIT -> IDLE, err stays 0.
- k_dout mirrors k and is held stable in IDLE until the next accepted ena.
- Timing: minimum overhead is 1 trigger cycle per helper invocation. Total run time = sum of helper durations + (2 + 2k + 2k + 2) FSM cycles.
- Helper ordering guarantee: at most one X_ena is high in any cycle, and no helper is started while another is in its WAIT state.
- k is K_NUM_BITS wide and never exceeds K_MAX. halve_cnt has the same width.

Optional Feature:
MODINV_SEQ_TIMEOUT_EN:
- Defined: a cycle counter clears on entry to each X_WAIT and X_TRIG state. If it reaches TIMEOUT_CYCLES before the exit condition, the FSM sets err=1 and goes to IDLE. Helpers are not reset by this abort.
- Undefined: no counter exists; the FSM waits indefinitely and err is set only by the iteration limit.

Test Plan:
1. Assert and release rst_n with no ena -> rdy=1, err=0, k_dout=0, all *_ena=0 for 20 cycles.
2. Stub helpers with 11-cycle busy; step_v_zero=1 on the 3rd step -> exactly 1 init_ena, 3 step_ena, 3 halve_ena, 1 copy_ena pulse in order; final k_dout=3, err=0, rdy=1.
3. step_v_zero held 0 -> 512 step_ena pulses, err=1, k_dout=512, zero halve_ena/copy_ena, rdy=1.
4. Pulse ena during STEP_WAIT and again during HALVE_WAIT -> no extra pulses; run result identical to scenario 2.
5. Hold step_rdy low for 5 cycles on entry to STEP_TRIG -> step_ena stays 0 until step_rdy rises, then a single pulse.
6. Drop rst_n mid-halve phase -> all outputs take reset values asynchronously; a rerun of scenario 2 then completes with k_dout=3.

Source files
------------

// File: rtl/modinv_sequencer.sv
// modinv_sequencer: top-level controller for the almost-inverse modular
// inverter. It sequences the init, step, halve and copy-out helpers, counts
// iterations (k) and flags non-invertible operands via an iteration limit.
// It holds no datapath; the helpers own all buffer access.
//
// Optional feature: define MODINV_SEQ_TIMEOUT_EN to add a per-state watchdog
// that aborts a run (err=1) when a helper stalls for TIMEOUT_CYCLES.
//
// Handshake: each helper X exposes X_rdy (idle). X_ena is a one-cycle start
// pulse driven combinationally in X_TRIG only while X_rdy=1. The helper drops
// X_rdy on the edge after the pulse, and the FSM leaves X_WAIT on the first
// cycle X_rdy is high again. ena is a request that is sampled only when rdy=1.
module modinv_sequencer #(
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int K_NUM_BITS        = 10,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  output logic                  rdy,
  output logic                  err,
  output logic [K_NUM_BITS-1:0] k_dout,
  output logic                  init_ena,
  input  logic                  init_rdy,
  output logic                  step_ena,
  input  logic                  step_rdy,
  input  logic                  step_v_zero,
  output logic                  halve_ena,
  input  logic                  halve_rdy,
  output logic                  copy_ena,
  input  logic                  copy_rdy,
  output logic [3:0]            dbg_state
);

  // Largest legal iteration count; reaching it without v==0 means the
  // operand has no inverse.
  localparam logic [K_NUM_BITS-1:0] K_MAX = K_NUM_BITS'(64 * OPERAND_NUM_WORDS);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT_TRIG  = 4'd1,
    INIT_WAIT  = 4'd2,
    STEP_TRIG  = 4'd3,
    STEP_WAIT  = 4'd4,
    HALVE_TRIG = 4'd5,
    HALVE_WAIT = 4'd6,
    COPY_TRIG  = 4'd7,
    COPY_WAIT  = 4'd8
  } state_t;

  state_t                state, state_next;
  logic [K_NUM_BITS-1:0] k, k_next;
  logic [K_NUM_BITS-1:0] halve_cnt, halve_next;
  logic                  err_next;
  logic [K_NUM_BITS-1:0] k_inc;

  assign k_inc     = k + K_NUM_BITS'(1);
  assign k_dout    = k;
  assign dbg_state = state;

`ifdef MODINV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog counts cycles spent in the current state; any state change
  // (entry to a new TRIG or WAIT) restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`endif

  // State and run-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      halve_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      halve_cnt <= halve_next;
      err       <= err_next;
    end
  end

  // Next-state, counter updates and helper start pulses.
  always_comb begin
    state_next = state;
    k_next     = k;
    halve_next = halve_cnt;
    err_next   = err;
    init_ena   = 1'b0;
    step_ena   = 1'b0;
    halve_ena  = 1'b0;
    copy_ena   = 1'b0;
    rdy        = (state == IDLE);

    case (state)
      IDLE: begin
        if (ena) begin
          err_next   = 1'b0;
          k_next     = '0;
          halve_next = '0;
          state_next = INIT_TRIG;
        end
      end
      INIT_TRIG: begin
        if (init_rdy) begin
          init_ena   = 1'b1;
          state_next = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (init_rdy) state_next = STEP_TRIG;
      end
      STEP_TRIG: begin
        if (step_rdy) begin
          step_ena   = 1'b1;
          state_next = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (step_rdy) begin
          k_next = k_inc;
          // v==0 wins over the limit: finishing on the K_MAX-th step is success.
          if (step_v_zero) begin
            halve_next = k_inc;
            state_next = HALVE_TRIG;
          end else if (k_inc == K_MAX) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = STEP_TRIG;
          end
        end
      end
      HALVE_TRIG: begin
        if (halve_rdy) begin
          halve_ena  = 1'b1;
          halve_next = halve_cnt - K_NUM_BITS'(1);
          state_next = HALVE_WAIT;
        end
      end
      HALVE_WAIT: begin
        if (halve_rdy) begin
          state_next = (halve_cnt == '0) ? COPY_TRIG : HALVE_TRIG;
        end
      end
      COPY_TRIG: begin
        if (copy_rdy) begin
          copy_ena   = 1'b1;
          state_next = COPY_WAIT;
        end
      end
      COPY_WAIT: begin
        if (copy_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef MODINV_SEQ_TIMEOUT_EN
    // A stalled helper never lets the state advance, so no pulse is being
    // issued when the abort fires; the helper itself is left alone.
    if ((state != IDLE) && (state_next == state) &&
        (tmo_cnt == TW'(TIMEOUT_CYCLES))) begin
      err_next   = 1'b1;
      state_next = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_modinv_sequencer.sv
// tb_modinv_sequencer: directed + randomized bench for modinv_sequencer.
// Helper stubs with programmable busy time stand in for the datapath; a
// reference model derives the expected pulse sequence, k, err and run length
// from the run's step count and the helper durations.
module tb_modinv_sequencer;

  localparam int KW     = 10;
  localparam int K_MAX  = 512;
  localparam int BUDGET = 20000;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          rdy;
  logic          err;
  logic [KW-1:0] k_dout;
  logic          init_ena, init_rdy;
  logic          step_ena, step_rdy, step_v_zero;
  logic          halve_ena, halve_rdy;
  logic          copy_ena, copy_rdy;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Stub configuration, driven by the stimulus.
  int   init_dur, step_dur, halve_dur, copy_dur;
  int   v_target;     // step on which v becomes zero; 0 = never
  logic step_block;   // forces step helper to look busy

  int init_cnt, step_cnt, halve_cnt_s, copy_cnt;
  int step_pulses;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         exp_k, exp_err, exp_cyc;

  modinv_sequencer #(
    .OPERAND_NUM_WORDS(8),
    .K_NUM_BITS(KW),
    .TIMEOUT_CYCLES(1023)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rdy(rdy),
    .err(err),
    .k_dout(k_dout),
    .init_ena(init_ena),
    .init_rdy(init_rdy),
    .step_ena(step_ena),
    .step_rdy(step_rdy),
    .step_v_zero(step_v_zero),
    .halve_ena(halve_ena),
    .halve_rdy(halve_rdy),
    .copy_ena(copy_ena),
    .copy_rdy(copy_rdy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helper stubs ----------------
  assign init_rdy    = (init_cnt == 0);
  assign step_rdy    = (step_cnt == 0) && !step_block;
  assign halve_rdy   = (halve_cnt_s == 0);
  assign copy_rdy    = (copy_cnt == 0);
  assign step_v_zero = (v_target != 0) && (step_pulses == v_target);

  // Each stub goes busy for its duration on the edge that sees its pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt    <= 0;
      step_cnt    <= 0;
      halve_cnt_s <= 0;
      copy_cnt    <= 0;
      step_pulses <= 0;
    end else begin
      if (init_ena) begin
        init_cnt    <= init_dur;
        step_pulses <= 0;
      end else if (init_cnt > 0) init_cnt <= init_cnt - 1;
      if (step_ena) begin
        step_cnt    <= step_dur;
        step_pulses <= step_pulses + 1;
      end else if (step_cnt > 0) step_cnt <= step_cnt - 1;
      if (halve_ena) halve_cnt_s <= halve_dur;
      else if (halve_cnt_s > 0) halve_cnt_s <= halve_cnt_s - 1;
      if (copy_ena) copy_cnt <= copy_dur;
      else if (copy_cnt > 0) copy_cnt <= copy_cnt - 1;
    end
  end

  // Log of observed start pulses, in order.
  always @(posedge clk) begin
    if (rst_n) begin
      if (init_ena)  obs_q.push_back("I");
      if (step_ena)  obs_q.push_back("S");
      if (halve_ena) obs_q.push_back("H");
      if (copy_ena)  obs_q.push_back("C");
    end
  end

  // Ordering monitor: one pulse at a time, only to an idle helper, and never
  // while any helper is still busy.
  always @(negedge clk) begin
    if (rst_n && (init_ena || step_ena || halve_ena || copy_ena)) begin
      automatic int  n_ena = int'(init_ena) + int'(step_ena) + int'(halve_ena) + int'(copy_ena);
      automatic bit  busy  = (init_cnt != 0) || (step_cnt != 0) || (halve_cnt_s != 0) ||
                             (copy_cnt != 0) || (step_ena && step_block);
      automatic logic ok   = (n_ena == 1) && !busy;
      checks++;
      assert (ok === 1'b1) else begin
        errors++;
        $error("FAIL pulse_order observed=%0d pulses busy=%0d expected=1 pulse idle", n_ena, busy);
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {26'd0, rdy, err, init_ena, step_ena, halve_ena, copy_ena}, 32'h20);
    check({tag, "_k"}, 32'(k_dout), 32'd0);
  endtask

  // Reference model: a run whose v reaches zero on step n (n=0: never).
  function automatic void model_run(input int n);
    int steps;
    exp_q.delete();
    steps = (n == 0) ? K_MAX : n;
    exp_q.push_back("I");
    for (int i = 0; i < steps; i++) exp_q.push_back("S");
    if (n != 0) begin
      for (int i = 0; i < n; i++) exp_q.push_back("H");
      exp_q.push_back("C");
    end
    exp_k   = steps;
    exp_err = (n == 0) ? 1 : 0;
    // Each invocation: one trigger cycle, dur busy cycles, one cycle seeing rdy.
    exp_cyc = (init_dur + 2) + steps * (step_dur + 2);
    if (n != 0) exp_cyc += n * (halve_dur + 2) + (copy_dur + 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_run(input int n, input int di, input int ds, input int dh, input int dc);
    init_dur  = di;
    step_dur  = ds;
    halve_dur = dh;
    copy_dur  = dc;
    v_target  = n;
    model_run(n);
    obs_q.delete();
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic finish_run(input string tag, input bit noise, input bit chk_cyc);
    int cyc;
    int mis;
    cyc = 0;
    while (rdy == 1'b0 && cyc < BUDGET) begin
      cyc++;
      ena = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
    end
    ena = 1'b0;
    if (cyc >= BUDGET) check({tag, "_timeout"}, 32'(rdy), 32'd1);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_k"}, 32'(k_dout), 32'(exp_k));
    check({tag, "_npulse"}, 32'(obs_q.size()), 32'(exp_q.size()));
    mis = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (mis < 0 && obs_q[i] != exp_q[i]) mis = i;
    end
    check({tag, "_seq_first_diff"}, 32'(mis), 32'hFFFF_FFFF);
    if (chk_cyc) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    step_block = 1'b0;
    v_target   = 0;
    init_dur   = 1;
    step_dur   = 1;
    halve_dur  = 1;
    copy_dur   = 1;

    // 1: reset, then idle with no request for 20 cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_idle");
    end

    // 2: 11-cycle helpers, v==0 on step 3.
    start_run(3, 11, 11, 11, 11);
    finish_run("basic3", 1'b0, 1'b1);

    // 3: v never reaches zero -> iteration limit.
    start_run(0, 2, 1, 1, 1);
    finish_run("limit", 1'b0, 1'b1);

    // Boundary: success exactly on the K_MAX-th step is not an error.
    start_run(K_MAX, 1, 1, 1, 1);
    finish_run("kmax_ok", 1'b0, 1'b1);

    // Boundary: a single step.
    start_run(1, 3, 2, 4, 5);
    finish_run("one_step", 1'b0, 1'b1);

    // 4: ena noise throughout the run must not add pulses.
    start_run(3, 11, 11, 11, 11);
    finish_run("noise3", 1'b1, 1'b1);

    // 5: step helper held busy as STEP_TRIG is entered.
    step_block = 1'b1;
    start_run(1, 2, 2, 2, 2);
    begin
      int guard;
      guard = 0;
      while (!(obs_q.size() > 0 && init_rdy) && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      check("block_init_done", 32'(guard < 100), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("block_step_ena_low", 32'(step_ena), 32'd0);
    end
    step_block = 1'b0;
    #1;
    check("block_step_pulse", 32'(step_ena), 32'd1);
    @(negedge clk);
    check("block_single_pulse", 32'(step_ena), 32'd0);
    finish_run("block", 1'b0, 1'b0);

    // 6: asynchronous reset in the middle of the halve phase.
    start_run(3, 11, 11, 11, 11);
    begin
      int guard;
      guard = 0;
      while (!halve_ena && guard < 500) begin
        guard++;
        @(negedge clk);
      end
      check("reach_halve", 32'(guard < 500), 32'd1);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_run(3, 11, 11, 11, 11);
    finish_run("rerun3", 1'b0, 1'b1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      start_run($urandom_range(1, 24), $urandom_range(1, 6), $urandom_range(1, 6),
                $urandom_range(1, 6), $urandom_range(1, 6));
      finish_run("rand", $urandom_range(0, 1) == 1, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
